// File: rtl/fetch_stage_if.sv
// SRAM-like instruction port between fetch_stage (master) and instruction memory (slave).
interface fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;

    modport master (output inst_req, output inst_addr, input inst_addr_ok);
    modport slave  (input inst_req, input inst_addr, output inst_addr_ok);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch in flight and hands
// {pc, cancel, exception} to decode. Define FETCH_PERF_CNT_EN to add perf counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [4:0]  EXC_ADEL = 5'h04
) (
    input  logic          clk,
    input  logic          resetn,
    fetch_stage_if.master inst,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    input  logic          exc_redirect,
    input  logic [31:0]   exc_target,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [31:0]   pc_o,
    output logic          cancelled_o,
    output logic          exc_o,
    output logic          exc_miss_o,
    output logic [4:0]    exccode_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_req_cnt,
    output logic [31:0]   perf_cancel_cnt
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_ERR} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bd_target_q, bd_target_d;
    logic        bd_pend_q, bd_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        redir_q, redir_d;
    logic        valid_d, cancelled_d, exc_d;
    logic [31:0] pc_o_d;
    logic [4:0]  exccode_d;
    logic        aligned;
    logic        handshake;

    assign aligned           = (pc_q[1:0] == 2'b00);
    assign inst.inst_req     = resetn && (state_q == S_REQ) && aligned;
    assign inst.inst_addr    = pc_q;
    assign handshake         = inst.inst_req && inst.inst_addr_ok;
    assign exc_miss_o        = 1'b0;

    always_comb begin
        // NOTE: every target gets its hold value first, so no path through the case can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        bd_target_d = bd_target_q;
        bd_pend_d   = bd_pend_q;
        redir_pc_d  = redir_pc_q;
        redir_d     = redir_q;
        valid_d     = valid_o;
        pc_o_d      = pc_o;
        cancelled_d = cancelled_o;
        exc_d       = exc_o;
        exccode_d   = exccode_o;

        unique case (state_q)
            S_REQ: begin
                if (!aligned || handshake) begin
                    valid_d = 1'b1;
                    pc_o_d  = pc_q;
                    state_d = aligned ? S_WAIT : S_ERR;
                    if (!aligned) begin
                        exc_d     = 1'b1;
                        exccode_d = EXC_ADEL;
                    end
                    // A flush seen while the request was held, or right now, kills the new entry.
                    if (exc_redirect || redir_q) begin
                        cancelled_d = 1'b1;
                        pc_d        = exc_redirect ? exc_target : redir_pc_q;
                        redir_d     = 1'b0;
                    end
                end else if (exc_redirect) begin
                    // The bus request must stay stable, so park the new target until it is accepted.
                    redir_d    = 1'b1;
                    redir_pc_d = exc_target;
                end
            end
            S_WAIT, S_ERR: begin
                if (ready_i) begin
                    valid_d     = 1'b0;
                    cancelled_d = 1'b0;
                    exc_d       = 1'b0;
                    exccode_d   = '0;
                    state_d     = S_REQ;
                    // A cancelled entry already left pc pointing at the redirect target.
                    if (!cancelled_o) begin
                        pc_d      = bd_pend_q ? bd_target_q : pc_o + 32'd4;
                        bd_pend_d = 1'b0;
                        if (br_taken) begin
                            bd_target_d = br_target;
                            bd_pend_d   = 1'b1;
                        end
                    end
                end else if (exc_redirect) begin
                    cancelled_d = 1'b1;
                end
                if (exc_redirect) pc_d = exc_target;
            end
            default: state_d = S_REQ;
        endcase

        if (exc_redirect) bd_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            bd_target_q <= '0;
            bd_pend_q   <= 1'b0;
            redir_pc_q  <= '0;
            redir_q     <= 1'b0;
            valid_o     <= 1'b0;
            pc_o        <= '0;
            cancelled_o <= 1'b0;
            exc_o       <= 1'b0;
            exccode_o   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            bd_target_q <= bd_target_d;
            bd_pend_q   <= bd_pend_d;
            redir_pc_q  <= redir_pc_d;
            redir_q     <= redir_d;
            valid_o     <= valid_d;
            pc_o        <= pc_o_d;
            cancelled_o <= cancelled_d;
            exc_o       <= exc_d;
            exccode_o   <= exccode_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_req_cnt    <= '0;
            perf_cancel_cnt <= '0;
        end else begin
            if (handshake) perf_req_cnt <= perf_req_cnt + 32'd1;
            if (valid_o && cancelled_o && ready_i) perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked against
// a queue-based model of the fetch address stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_taken, exc_redirect, ready_i;
    logic [31:0] br_target, exc_target;
    logic        valid_o, cancelled_o, exc_o, exc_miss_o;
    logic [31:0] pc_o;
    logic [4:0]  exccode_o;
    int          tests = 0;
    int          fails = 0;

    // Model: upcoming fetch addresses in order, the address being requested, and the live entry.
    logic [31:0] nxt[$];
    logic [31:0] m_cur, m_epc;
    logic        m_have_cur, m_busy, m_killed, m_ecan, m_eexc;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst         (bus),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .cancelled_o  (cancelled_o),
        .exc_o        (exc_o),
        .exc_miss_o   (exc_miss_o),
        .exccode_o    (exccode_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs with the model, drive inputs, advance, update the model.
    task automatic step(input logic aok, input logic rdy, input logic br, input logic [31:0] bt,
                        input logic exc, input logic [31:0] et);
        logic exp_req, a, r, b;
        if (!m_busy && !m_have_cur) begin
            m_cur      = nxt.pop_front();
            m_have_cur = 1'b1;
        end
        exp_req = !m_busy && (m_cur[1:0] == 2'b00);
        check("inst_req", 32'(bus.inst_req), 32'(exp_req));
        check("valid_o", 32'(valid_o), 32'(m_busy));
        if (exp_req) check("inst_addr", bus.inst_addr, m_cur);
        if (m_busy) begin
            check("pc_o", pc_o, m_epc);
            check("cancelled_o", 32'(cancelled_o), 32'(m_ecan));
            check("exc_o", 32'(exc_o), 32'(m_eexc));
            check("exccode_o", 32'(exccode_o), m_eexc ? 32'h4 : 32'h0);
        end
        a = aok && exp_req;
        r = rdy && m_busy;
        b = br && r && !m_ecan;
        bus.inst_addr_ok = a;
        ready_i          = r;
        br_taken         = b;
        br_target        = bt;
        exc_redirect     = exc;
        exc_target       = et;
        @(posedge clk);
        #1;
        bus.inst_addr_ok = 1'b0;
        ready_i          = 1'b0;
        br_taken         = 1'b0;
        exc_redirect     = 1'b0;

        if (!m_busy) begin
            if (m_cur[1:0] != 2'b00 || a) begin
                m_busy     = 1'b1;
                m_epc      = m_cur;
                m_eexc     = (m_cur[1:0] != 2'b00);
                m_ecan     = m_killed || exc;
                m_killed   = 1'b0;
                m_have_cur = 1'b0;
            end else if (exc) begin
                m_killed = 1'b1;
            end
        end else if (r) begin
            m_busy = 1'b0;
            if (!m_ecan) begin
                if (nxt.size() == 0) nxt.push_back(m_epc + 32'd4);
                if (b) nxt.push_back(bt);
            end
        end else if (exc) begin
            m_ecan = 1'b1;
        end
        if (exc) nxt = {et};
    endtask

    initial begin
        logic [31:0] bt, et;
        bus.inst_addr_ok = 1'b0;
        br_taken = 1'b0; br_target = '0; exc_redirect = 1'b0; exc_target = '0; ready_i = 1'b0;
        nxt = {32'hbfc00000};
        m_cur = '0; m_epc = '0;
        m_have_cur = 1'b0; m_busy = 1'b0; m_killed = 1'b0; m_ecan = 1'b0; m_eexc = 1'b0;

        #12;
        check("rst_inst_req", 32'(bus.inst_req), 32'h0);
        check("rst_valid_o", 32'(valid_o), 32'h0);
        check("rst_cancelled_o", 32'(cancelled_o), 32'h0);
        check("rst_exc_o", 32'(exc_o), 32'h0);
        check("rst_exccode_o", 32'(exccode_o), 32'h0);
        check("rst_exc_miss_o", 32'(exc_miss_o), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // First fetch accepted at once, consumed three cycles later.
        check("first_addr", bus.inst_addr, 32'hbfc00000);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("seq_req", 32'(bus.inst_req), 32'h1);
        check("seq_addr", bus.inst_addr, 32'hbfc00004);

        // addr_ok withheld: request and address must hold steady.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check("hold_addr", bus.inst_addr, 32'hbfc00004);
            check("hold_valid", 32'(valid_o), 32'h0);
        end
        step(1, 0, 0, 0, 0, 0);

        // Redirect together with ready_i: next fetch is the target, not cancelled.
        step(0, 1, 0, 0, 1, 32'h80000010);
        check("redir_ready_addr", bus.inst_addr, 32'h80000010);
        step(1, 0, 0, 0, 0, 0);
        check("redir_ready_cancel", 32'(cancelled_o), 32'h0);

        // Taken branch: delay slot first, then the target.
        step(0, 1, 1, 32'h80000100, 0, 0);
        check("delay_slot_addr", bus.inst_addr, 32'h80000014);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("branch_target_addr", bus.inst_addr, 32'h80000100);
        step(1, 0, 0, 0, 0, 0);

        // Exception during WAIT: entry cancelled until ready_i.
        step(0, 0, 0, 0, 1, 32'h80000380);
        check("wait_exc_cancel", 32'(cancelled_o), 32'h1);
        step(0, 0, 0, 0, 0, 0);
        check("wait_exc_cancel_held", 32'(cancelled_o), 32'h1);
        step(0, 1, 0, 0, 0, 0);
        check("wait_exc_next", bus.inst_addr, 32'h80000380);

        // Exception beats a same-cycle branch; the delay slot is dropped.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h80000500, 1, 32'h80000380);
        check("exc_br_addr", bus.inst_addr, 32'h80000380);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("exc_br_no_target", bus.inst_addr, 32'h80000384);

        // Misaligned branch target raises AdEL without a request.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h80000102, 0, 0);
        check("adel_delay_slot", bus.inst_addr, 32'h80000388);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("adel_no_req", 32'(bus.inst_req), 32'h0);
        step(0, 0, 0, 0, 0, 0);
        check("adel_valid", 32'(valid_o), 32'h1);
        check("adel_exc", 32'(exc_o), 32'h1);
        check("adel_code", 32'(exccode_o), 32'h4);
        check("adel_pc", pc_o, 32'h80000102);

        // Exception while a request is held: it completes cancelled, then the target is fetched.
        step(0, 1, 0, 0, 1, 32'h80001000);
        step(0, 0, 0, 0, 1, 32'h80002000);
        check("req_exc_hold_addr", bus.inst_addr, 32'h80001000);
        step(1, 0, 0, 0, 0, 0);
        check("req_exc_cancel", 32'(cancelled_o), 32'h1);
        check("req_exc_pc", pc_o, 32'h80001000);
        step(0, 1, 0, 0, 0, 0);
        check("req_exc_next", bus.inst_addr, 32'h80002000);

        // PC wraps past the top of the address space.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'hfffffffc);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("wrap_addr", bus.inst_addr, 32'h00000000);

        // Random memory latency, decode back-pressure, branches and flushes.
        for (int i = 0; i < 1500; i++) begin
            bt = ($urandom & 32'hfffffffc) | (($urandom_range(0, 9) == 0) ? 32'h2 : 32'h0);
            et = $urandom & 32'hfffffffc;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 bt, $urandom_range(0, 15) == 0, et);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
